// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared definitions for the control sequencer.
// Holds opcode constants, the sequencer state enum, the control-word bit map
// (single-bit strobes plus a 3-bit ALU operation field), ALU op codes and
// small helpers that build control words and map states to T-step indices.
package ctrl_seq_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'h00;
  localparam logic [OP_W-1:0] OP_LDI  = 5'h01;
  localparam logic [OP_W-1:0] OP_ST   = 5'h02;
  localparam logic [OP_W-1:0] OP_ADD  = 5'h03;
  localparam logic [OP_W-1:0] OP_SUB  = 5'h04;
  localparam logic [OP_W-1:0] OP_AND  = 5'h05;
  localparam logic [OP_W-1:0] OP_OR   = 5'h06;
  localparam logic [OP_W-1:0] OP_ADDI = 5'h0C;
  localparam logic [OP_W-1:0] OP_MUL  = 5'h0F;
  localparam logic [OP_W-1:0] OP_DIV  = 5'h10;
  localparam logic [OP_W-1:0] OP_BR   = 5'h12;
  localparam logic [OP_W-1:0] OP_JR   = 5'h13;
  localparam logic [OP_W-1:0] OP_NOP  = 5'h1A;
  localparam logic [OP_W-1:0] OP_HALT = 5'h1B;

  // T-states occupy 0..7 so the low bits are the step index; bit 3 marks non-T states
  typedef enum logic [3:0] {
    S_T0    = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_T3    = 4'd3,
    S_T4    = 4'd4,
    S_T5    = 4'd5,
    S_T6    = 4'd6,
    S_T7    = 4'd7,
    S_IDLE  = 4'd8,
    S_HALT  = 4'd9,
    S_FAULT = 4'd10
  } state_t;

  localparam int unsigned ALU_W = 3;

  localparam logic [ALU_W-1:0] ALU_NONE = 3'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'd3;
  localparam logic [ALU_W-1:0] ALU_OR   = 3'd4;
  localparam logic [ALU_W-1:0] ALU_MUL  = 3'd5;
  localparam logic [ALU_W-1:0] ALU_DIV  = 3'd6;

  // Control word bit indices
  localparam int unsigned C_PCOUT    = 0;
  localparam int unsigned C_MARIN    = 1;
  localparam int unsigned C_INCPC    = 2;
  localparam int unsigned C_ZIN      = 3;
  localparam int unsigned C_ZLOWOUT  = 4;
  localparam int unsigned C_PCIN     = 5;
  localparam int unsigned C_READ     = 6;
  localparam int unsigned C_MDRIN    = 7;
  localparam int unsigned C_MDROUT   = 8;
  localparam int unsigned C_IRIN     = 9;
  localparam int unsigned C_GRA      = 10;
  localparam int unsigned C_GRB      = 11;
  localparam int unsigned C_GRC      = 12;
  localparam int unsigned C_RIN      = 13;
  localparam int unsigned C_ROUT     = 14;
  localparam int unsigned C_BAOUT    = 15;
  localparam int unsigned C_YIN      = 16;
  localparam int unsigned C_COUT     = 17;
  localparam int unsigned C_CONIN    = 18;
  localparam int unsigned C_WRITE    = 19;
  localparam int unsigned C_LOIN     = 20;
  localparam int unsigned C_HIIN     = 21;
  localparam int unsigned C_ZHIGHOUT = 22;
  localparam int unsigned C_ALU_LSB  = 23;

  localparam int unsigned CTRL_W = C_ALU_LSB + ALU_W;

  // One-hot strobe at bit position idx
  function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
    return CTRL_W'(1) << idx;
  endfunction

  // ALU operation placed in its control-word field
  function automatic logic [CTRL_W-1:0] calu(input logic [ALU_W-1:0] op);
    return CTRL_W'(op) << C_ALU_LSB;
  endfunction

  // T index for T-states, 0 for IDLE/HALT/FAULT
  function automatic logic [2:0] state_step(input state_t s);
    return s[3] ? 3'd0 : s[2:0];
  endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// ctrl_seq_decode: combinational microcode table.
// Maps (opcode, T-step, con_ff) to the control word for that step, whether
// the opcode is defined, and whether the step is the instruction's last.
// Ports:
//   i_opcode  opcode field of the instruction
//   i_step    T-step index 0..7
//   i_con_ff  branch condition flag (only affects br T6)
//   o_ctrl    control word for the step
//   o_legal   opcode is defined (always 1 for fetch steps)
//   o_last    step is the final step of the instruction
// Build option: CTRL_SEQ_MULDIV_EN adds mul/div decode; otherwise they are undefined.
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [2:0]          i_step,
  input  logic                i_con_ff,
  output logic [CTRL_W-1:0]   o_ctrl,
  output logic                o_legal,
  output logic                o_last
);

  logic [ALU_W-1:0] w_rr_alu;

  // Microcode lookup
  always_comb begin
    o_ctrl   = '0;
    o_legal  = 1'b1;
    o_last   = 1'b0;
    w_rr_alu = ALU_ADD;
    if (i_step < 3'd3) begin
      // Fetch is common to all opcodes
      case (i_step)
        3'd0:    o_ctrl = cbit(C_PCOUT) | cbit(C_MARIN) | cbit(C_INCPC) | cbit(C_ZIN);
        3'd1:    o_ctrl = cbit(C_ZLOWOUT) | cbit(C_PCIN) | cbit(C_READ) | cbit(C_MDRIN);
        default: o_ctrl = cbit(C_MDROUT) | cbit(C_IRIN);
      endcase
    end else begin
      case (i_opcode)
        OPCODE_W'(OP_LDI), OPCODE_W'(OP_LD), OPCODE_W'(OP_ST): begin
          // Effective address = (rb or 0) + C, shared by the three memory ops
          case (i_step)
            3'd3: o_ctrl = cbit(C_GRB) | cbit(C_BAOUT) | cbit(C_YIN);
            3'd4: o_ctrl = cbit(C_COUT) | calu(ALU_ADD) | cbit(C_ZIN);
            3'd5: begin
              if (i_opcode == OPCODE_W'(OP_LDI)) begin
                o_ctrl = cbit(C_ZLOWOUT) | cbit(C_GRA) | cbit(C_RIN);
                o_last = 1'b1;
              end else begin
                o_ctrl = cbit(C_ZLOWOUT) | cbit(C_MARIN);
              end
            end
            3'd6: begin
              if (i_opcode == OPCODE_W'(OP_LD))
                o_ctrl = cbit(C_READ) | cbit(C_MDRIN);
              else
                o_ctrl = cbit(C_GRA) | cbit(C_ROUT) | cbit(C_MDRIN);
            end
            default: begin
              o_last = 1'b1;
              if (i_opcode == OPCODE_W'(OP_LD))
                o_ctrl = cbit(C_MDROUT) | cbit(C_GRA) | cbit(C_RIN);
              else
                o_ctrl = cbit(C_WRITE);
            end
          endcase
        end

        OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_AND), OPCODE_W'(OP_OR): begin
          if (i_opcode == OPCODE_W'(OP_SUB))      w_rr_alu = ALU_SUB;
          else if (i_opcode == OPCODE_W'(OP_AND)) w_rr_alu = ALU_AND;
          else if (i_opcode == OPCODE_W'(OP_OR))  w_rr_alu = ALU_OR;
          case (i_step)
            3'd3: o_ctrl = cbit(C_GRB) | cbit(C_ROUT) | cbit(C_YIN);
            3'd4: o_ctrl = cbit(C_GRC) | cbit(C_ROUT) | calu(w_rr_alu) | cbit(C_ZIN);
            default: begin
              o_ctrl = cbit(C_ZLOWOUT) | cbit(C_GRA) | cbit(C_RIN);
              o_last = 1'b1;
            end
          endcase
        end

        OPCODE_W'(OP_ADDI): begin
          case (i_step)
            3'd3: o_ctrl = cbit(C_GRB) | cbit(C_ROUT) | cbit(C_YIN);
            3'd4: o_ctrl = cbit(C_COUT) | calu(ALU_ADD) | cbit(C_ZIN);
            default: begin
              o_ctrl = cbit(C_ZLOWOUT) | cbit(C_GRA) | cbit(C_RIN);
              o_last = 1'b1;
            end
          endcase
        end

        OPCODE_W'(OP_BR): begin
          case (i_step)
            3'd3: o_ctrl = cbit(C_GRA) | cbit(C_ROUT) | cbit(C_CONIN);
            3'd4: o_ctrl = cbit(C_PCOUT) | cbit(C_YIN);
            3'd5: o_ctrl = cbit(C_COUT) | calu(ALU_ADD) | cbit(C_ZIN);
            default: begin
              // Branch target is written back only when the condition holds
              if (i_con_ff) o_ctrl = cbit(C_ZLOWOUT) | cbit(C_PCIN);
              o_last = 1'b1;
            end
          endcase
        end

        OPCODE_W'(OP_JR): begin
          o_ctrl = cbit(C_GRA) | cbit(C_ROUT) | cbit(C_PCIN);
          o_last = 1'b1;
        end

        OPCODE_W'(OP_NOP), OPCODE_W'(OP_HALT): begin
          o_last = 1'b1;
        end

`ifdef CTRL_SEQ_MULDIV_EN
        OPCODE_W'(OP_MUL), OPCODE_W'(OP_DIV): begin
          case (i_step)
            3'd3: o_ctrl = cbit(C_GRA) | cbit(C_ROUT) | cbit(C_YIN);
            3'd4: o_ctrl = cbit(C_GRB) | cbit(C_ROUT) | cbit(C_ZIN) |
                           calu((i_opcode == OPCODE_W'(OP_MUL)) ? ALU_MUL : ALU_DIV);
            3'd5: o_ctrl = cbit(C_ZLOWOUT) | cbit(C_LOIN);
            default: begin
              o_ctrl = cbit(C_ZHIGHOUT) | cbit(C_HIIN);
              o_last = 1'b1;
            end
          endcase
        end
`endif

        default: o_legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-step control unit.
// Walks IDLE -> T0..T7 per instruction, holding memory steps until mem_rdy,
// with HALT and FAULT terminal states. The control word and status outputs
// are registered and reflect the step the sequencer is currently in.
// Ports:
//   clk      system clock
//   clr      synchronous active-high reset
//   run      start/resume request (IDLE, HALT)
//   ir       instruction register; opcode in ir[31 -: OPCODE_W]
//   con_ff   branch condition flag
//   mem_rdy  memory access complete
//   ctrl     packed control word (bit map in ctrl_seq_pkg)
//   step     current T-step index, 0 outside T-states
//   busy     in a T-step
//   halted   in HALT
//   fault    in FAULT
// Build option: CTRL_SEQ_MULDIV_EN enables mul/div (decoded in ctrl_seq_decode).
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic [31:0]       ir,
  input  logic              con_ff,
  input  logic              mem_rdy,
  output logic [CTRL_W-1:0] ctrl,
  output logic [2:0]        step,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [CTRL_W-1:0]   w_ctrl_next;
  logic [CTRL_W-1:0]   w_dec_ctrl;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_next;
  logic [OPCODE_W-1:0] r_opcode;
  logic [OPCODE_W-1:0] w_ir_op;
  logic [OPCODE_W-1:0] w_dec_op;
  logic [2:0]          r_step;
  logic [2:0]          w_next_step;
  logic                r_legal;
  logic                r_last;
  logic                w_dec_legal;
  logic                w_dec_last;
  logic                w_hold;
  logic                w_mem_step;
  logic                r_busy;
  logic                r_halted;
  logic                r_fault;
  logic                w_unused_ir;

  assign w_ir_op     = ir[31 -: OPCODE_W];
  assign w_unused_ir = ^ir[31-OPCODE_W:0];

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_ctrl   <= '0;
      r_wait   <= '0;
      r_opcode <= '0;
      r_step   <= 3'd0;
      r_legal  <= 1'b1;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_ctrl   <= w_ctrl_next;
      r_wait   <= w_wait_next;
      r_step   <= w_next_step;
      r_legal  <= w_dec_legal;
      r_last   <= w_dec_last;
      r_busy   <= ~w_next_state[3];
      r_halted <= (w_next_state == S_HALT);
      r_fault  <= (w_next_state == S_FAULT);
      // Opcode captured on entry to T3 and used for the rest of the instruction
      if (w_next_state == S_T3) r_opcode <= w_ir_op;
    end
  end

  // Next-state logic, including memory hold and timeout
  always_comb begin
    w_next_state = r_state;
    w_wait_next  = '0;
    w_hold       = 1'b0;
    w_mem_step   = r_ctrl[C_READ] | r_ctrl[C_WRITE];
    case (r_state)
      S_IDLE, S_HALT: begin
        if (run) w_next_state = S_T0;
      end
      S_FAULT: begin
        w_next_state = S_FAULT;
      end
      default: begin
        if (w_mem_step && !mem_rdy) begin
          if (r_wait == WAIT_W'(MEM_TIMEOUT - 1)) begin
            w_next_state = S_FAULT;
          end else begin
            w_hold      = 1'b1;
            w_wait_next = r_wait + WAIT_W'(1);
          end
        end else if (!r_legal) begin
          w_next_state = S_FAULT;
        end else if (r_last) begin
          w_next_state = (r_opcode == OPCODE_W'(OP_HALT)) ? S_HALT : S_T0;
        end else begin
          w_next_state = state_t'(r_state + 4'd1);
        end
      end
    endcase
  end

  // Decode the step being entered; T3 looks at ir directly since r_opcode loads on that edge
  assign w_next_step = state_step(w_next_state);
  assign w_dec_op    = (w_next_state == S_T3) ? w_ir_op : r_opcode;

  ctrl_seq_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .i_opcode (w_dec_op),
    .i_step   (w_next_step),
    .i_con_ff (con_ff),
    .o_ctrl   (w_dec_ctrl),
    .o_legal  (w_dec_legal),
    .o_last   (w_dec_last)
  );

  // Control word for the next cycle; frozen while a memory step is held
  always_comb begin
    w_ctrl_next = '0;
    if (w_hold)
      w_ctrl_next = r_ctrl;
    else if (!w_next_state[3])
      w_ctrl_next = w_dec_ctrl;
  end

  assign ctrl   = r_ctrl;
  assign step   = r_step;
  assign busy   = r_busy;
  assign halted = r_halted;
  assign fault  = r_fault;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each directed program pushes its
// hand-derived per-cycle trace; a monitor pops and compares whenever the
// sequencer is active (busy, halted or fault).
module tb_control_sequencer;
  import ctrl_seq_pkg::*;

  localparam int unsigned CW = CTRL_W;

  logic          clk = 1'b0;
  logic          clr;
  logic          run;
  logic [31:0]   ir;
  logic          con_ff;
  logic          mem_rdy;
  logic [CW-1:0] ctrl;
  logic [2:0]    step;
  logic          busy;
  logic          halted;
  logic          fault;

  typedef struct packed {
    logic [2:0]    step;
    logic [CW-1:0] ctrl;
    logic          halted;
    logic          fault;
  } exp_t;

  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  string cur_tag = "reset";

  always #5 clk = ~clk;

  control_sequencer #(
    .OPCODE_W    (5),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .run     (run),
    .ir      (ir),
    .con_ff  (con_ff),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl),
    .step    (step),
    .busy    (busy),
    .halted  (halted),
    .fault   (fault)
  );

  function automatic logic [CW-1:0] b(input int unsigned i);
    logic [CW-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [CW-1:0] a(input logic [2:0] op);
    logic [CW-1:0] v;
    v = '0;
    v[C_ALU_LSB +: 3] = op;
    return v;
  endfunction

  function automatic logic [CW-1:0] f0();
    return b(C_PCOUT) | b(C_MARIN) | b(C_INCPC) | b(C_ZIN);
  endfunction
  function automatic logic [CW-1:0] f1();
    return b(C_ZLOWOUT) | b(C_PCIN) | b(C_READ) | b(C_MDRIN);
  endfunction
  function automatic logic [CW-1:0] f2();
    return b(C_MDROUT) | b(C_IRIN);
  endfunction

  task automatic pt(input int s, input logic [CW-1:0] c);
    exp_t e;
    e.step = 3'(s); e.ctrl = c; e.halted = 1'b0; e.fault = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic ph();
    exp_t e;
    e.step = 3'd0; e.ctrl = '0; e.halted = 1'b1; e.fault = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic pf();
    exp_t e;
    e.step = 3'd0; e.ctrl = '0; e.halted = 1'b0; e.fault = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic fetch();
    pt(0, f0()); pt(1, f1()); pt(2, f2());
  endtask

  // Monitor: compare every active cycle against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (busy || halted || fault) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s unexpected: got step=%0d ctrl=%h busy=%b halted=%b fault=%b, required idle",
                 cur_tag, step, ctrl, busy, halted, fault);
      end else begin
        e = exp_q.pop_front();
        if (step !== e.step || ctrl !== e.ctrl || halted !== e.halted || fault !== e.fault ||
            busy !== (!e.halted && !e.fault)) begin
          n_bad++;
          $display("FAIL %s trace: got step=%0d ctrl=%h busy=%b halted=%b fault=%b, required step=%0d ctrl=%h busy=%b halted=%b fault=%b",
                   cur_tag, step, ctrl, busy, halted, fault,
                   e.step, e.ctrl, !e.halted && !e.fault, e.halted, e.fault);
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    n_vec++;
    if (ctrl !== '0 || step !== 3'd0 || busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle: got ctrl=%h step=%0d busy=%b halted=%b fault=%b, required all zero",
               tag, ctrl, step, busy, halted, fault);
    end
  endtask

  // Drive n cycles of run/mem_rdy from masks (bit k = cycle k), then clr and check idle
  task automatic run_prog(input string tag, input logic [4:0] op, input logic con, input int n,
                          input logic [63:0] rdy_m, input logic [63:0] run_m);
    cur_tag = tag;
    ir      = {op, 27'd0};
    con_ff  = con;
    for (int k = 0; k < n; k++) begin
      run     = run_m[k];
      mem_rdy = rdy_m[k];
      @(negedge clk);
    end
    run     = 1'b0;
    mem_rdy = 1'b1;
    clr     = 1'b1;
    @(negedge clk);
    check_idle({tag, "_clr"});
    clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; run = 1'b0; ir = '0; con_ff = 1'b0; mem_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    clr = 1'b0;

    // ldi: six steps then loops back to T0
    fetch();
    pt(3, b(C_GRB) | b(C_BAOUT) | b(C_YIN));
    pt(4, b(C_COUT) | a(ALU_ADD) | b(C_ZIN));
    pt(5, b(C_ZLOWOUT) | b(C_GRA) | b(C_RIN));
    pt(0, f0());
    run_prog("ldi", OP_LDI, 1'b0, 7, '1, 64'h1);

    // ld with three wait cycles in T1 and T6
    pt(0, f0());
    repeat (4) pt(1, f1());
    pt(2, f2());
    pt(3, b(C_GRB) | b(C_BAOUT) | b(C_YIN));
    pt(4, b(C_COUT) | a(ALU_ADD) | b(C_ZIN));
    pt(5, b(C_ZLOWOUT) | b(C_MARIN));
    repeat (4) pt(6, b(C_READ) | b(C_MDRIN));
    pt(7, b(C_MDROUT) | b(C_GRA) | b(C_RIN));
    pt(0, f0());
    run_prog("ld_hold", OP_LD, 1'b0, 15, 64'hFFFF_FFFF_FFFF_E3E3, 64'h1);

    // st
    fetch();
    pt(3, b(C_GRB) | b(C_BAOUT) | b(C_YIN));
    pt(4, b(C_COUT) | a(ALU_ADD) | b(C_ZIN));
    pt(5, b(C_ZLOWOUT) | b(C_MARIN));
    pt(6, b(C_GRA) | b(C_ROUT) | b(C_MDRIN));
    pt(7, b(C_WRITE));
    pt(0, f0());
    run_prog("st", OP_ST, 1'b0, 9, '1, 64'h1);

    // sub
    fetch();
    pt(3, b(C_GRB) | b(C_ROUT) | b(C_YIN));
    pt(4, b(C_GRC) | b(C_ROUT) | a(ALU_SUB) | b(C_ZIN));
    pt(5, b(C_ZLOWOUT) | b(C_GRA) | b(C_RIN));
    pt(0, f0());
    run_prog("sub", OP_SUB, 1'b0, 7, '1, 64'h1);

    // or
    fetch();
    pt(3, b(C_GRB) | b(C_ROUT) | b(C_YIN));
    pt(4, b(C_GRC) | b(C_ROUT) | a(ALU_OR) | b(C_ZIN));
    pt(5, b(C_ZLOWOUT) | b(C_GRA) | b(C_RIN));
    pt(0, f0());
    run_prog("or", OP_OR, 1'b0, 7, '1, 64'h1);

    // addi
    fetch();
    pt(3, b(C_GRB) | b(C_ROUT) | b(C_YIN));
    pt(4, b(C_COUT) | a(ALU_ADD) | b(C_ZIN));
    pt(5, b(C_ZLOWOUT) | b(C_GRA) | b(C_RIN));
    pt(0, f0());
    run_prog("addi", OP_ADDI, 1'b0, 7, '1, 64'h1);

    // br not taken, then taken
    for (int t = 0; t < 2; t++) begin
      fetch();
      pt(3, b(C_GRA) | b(C_ROUT) | b(C_CONIN));
      pt(4, b(C_PCOUT) | b(C_YIN));
      pt(5, b(C_COUT) | a(ALU_ADD) | b(C_ZIN));
      pt(6, (t == 1) ? (b(C_ZLOWOUT) | b(C_PCIN)) : '0);
      pt(0, f0());
      run_prog((t == 1) ? "br_taken" : "br_not_taken", OP_BR, (t == 1), 8, '1, 64'h1);
    end

    // jr
    fetch();
    pt(3, b(C_GRA) | b(C_ROUT) | b(C_PCIN));
    pt(0, f0());
    run_prog("jr", OP_JR, 1'b0, 5, '1, 64'h1);

    // nop
    fetch();
    pt(3, '0);
    pt(0, f0());
    run_prog("nop", OP_NOP, 1'b0, 5, '1, 64'h1);

    // halt, held for two cycles, then resumed by run
    fetch();
    pt(3, '0);
    ph(); ph();
    pt(0, f0());
    run_prog("halt", OP_HALT, 1'b0, 7, '1, 64'h41);

    // undefined opcode 1F: fault persists even with run
    fetch();
    pt(3, '0);
    pf(); pf(); pf();
    run_prog("undef_1f", 5'h1F, 1'b0, 7, '1, 64'h21);

    // mul
`ifdef CTRL_SEQ_MULDIV_EN
    fetch();
    pt(3, b(C_GRA) | b(C_ROUT) | b(C_YIN));
    pt(4, b(C_GRB) | b(C_ROUT) | a(ALU_MUL) | b(C_ZIN));
    pt(5, b(C_ZLOWOUT) | b(C_LOIN));
    pt(6, b(C_ZHIGHOUT) | b(C_HIIN));
    pt(0, f0());
    run_prog("mul", OP_MUL, 1'b0, 8, '1, 64'h1);
`else
    fetch();
    pt(3, '0);
    pf(); pf();
    run_prog("mul_undef", OP_MUL, 1'b0, 6, '1, 64'h1);
`endif

    // mem_rdy low 15 cycles in T1 -> fault
    pt(0, f0());
    repeat (15) pt(1, f1());
    pf(); pf(); pf();
    run_prog("timeout", OP_NOP, 1'b0, 19, 64'hFFFF_FFFF_FFFE_0003, 64'h1);

    // mem_rdy low 14 cycles then ready -> advances
    pt(0, f0());
    repeat (15) pt(1, f1());
    pt(2, f2());
    run_prog("wait_14", OP_NOP, 1'b0, 17, 64'hFFFF_FFFF_FFFF_0003, 64'h1);

    // clr while T1 is held abandons the read
    pt(0, f0());
    pt(1, f1());
    pt(1, f1());
    run_prog("clr_in_hold", OP_LD, 1'b0, 3, 64'h0, 64'h1);

    repeat (2) @(negedge clk);
    check_idle("final");
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d unconsumed expectations, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 5, width of the opcode field in ir[31 -: OPCODE_W].
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum cycles a memory step waits for mem_rdy.
REQ-003 Port clk  input  1  system clock, all state updates on rising edge.
REQ-004 Port clr  input  1  reset, synchronous and active-high.
REQ-005 Port run  input  1  start/resume request, sampled in IDLE and HALT.
REQ-006 Port ir  input  32  instruction register contents, sampled in T3.
REQ-007 Port con_ff  input  1  branch condition flag from the CON logic.
REQ-008 Port mem_rdy  input  1  memory access complete.
REQ-009 Port ctrl  output  CTRL_W  packed control word (bit map in package).
REQ-010 Port step  output  3  current T-step index 0..7.
REQ-011 Port busy  output  1  high in any T-step.
REQ-012 Port halted  output  1  high in HALT.
REQ-013 Port fault  output  1  high in FAULT.

Function
REQ-014 States: IDLE, T0..T7, HALT, FAULT; ctrl is registered, valid for the whole cycle of its step.
REQ-015 IDLE: ctrl=0; run=1 -> T0.
REQ-016 Fetch: T0 PCout,MARin,IncPC,Zin; T1 Zlowout,PCin,read,MDRin; T2 MDRout,IRin; all opcodes.
REQ-017 A step asserting read or write holds (ctrl unchanged) until mem_rdy=1, then advances next cycle.
REQ-018 Wait counter counts held cycles; reaching MEM_TIMEOUT without mem_rdy -> FAULT.
REQ-019 ldi: T3 Grb,BAout,Yin; T4 Cout,alu=ADD,Zin; T5 Zlowout,Gra,Rin; then T0.
REQ-020 ld: ldi T3-T4; T5 Zlowout,MARin; T6 read,MDRin; T7 MDRout,Gra,Rin; then T0.
REQ-021 st: ldi T3-T4; T5 Zlowout,MARin; T6 Gra,Rout,MDRin; T7 write; then T0.
REQ-022 add/sub/and/or: T3 Grb,Rout,Yin; T4 Grc,Rout,alu op,Zin; T5 Zlowout,Gra,Rin; then T0.
REQ-023 addi: T3 Grb,Rout,Yin; T4 Cout,alu=ADD,Zin; T5 Zlowout,Gra,Rin; then T0.
REQ-024 br: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,alu=ADD,Zin; T6 Zlowout,PCin only if con_ff=1 (else ctrl=0); then T0.
REQ-025 jr: T3 Gra,Rout,PCin; then T0. nop: T3 ctrl=0; then T0.
REQ-026 halt: T3 ctrl=0 -> HALT; HALT holds ctrl=0, run=1 -> T0.
REQ-027 Undefined opcode in T3 -> FAULT; FAULT holds ctrl=0 until clr.
REQ-028 step equals T index in T-states, 0 elsewhere; busy=1 only in T0..T7.

Reset
REQ-029 clr=1 at a rising edge -> IDLE, ctrl=0, step=0, busy=0, halted=0, fault=0, wait counter=0, regardless of state.
REQ-030 clr during a held memory step abandons the access; no read/write asserted next cycle.

Configuration
REQ-031 Macro CTRL_SEQ_MULDIV_EN defined: mul/div decode to T3 Gra,Rout,Yin; T4 Grb,Rout,alu=MUL/DIV,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin; then T0.
REQ-032 Macro undefined: mul/div opcodes are undefined -> FAULT per REQ-027.

Structure
REQ-033 Package ctrl_seq_pkg holds opcode constants (LD=00,LDI=01,ST=02,ADD=03,SUB=04,AND=05,OR=06,ADDI=0C,MUL=0F,DIV=10,BR=12,JR=13,NOP=1A,HALT=1B), state enum, ctrl bit indices, CTRL_W, alu op codes.
REQ-034 One sub-module ctrl_seq_decode: combinational (opcode, step, con_ff) -> ctrl word, legal flag, last-step flag.

Verification
REQ-035 clr=1 then run=1, ir=ldi (01), mem_rdy=1 -> steps 0..5, T5 ctrl=Zlowout|Gra|Rin, back to T0 on next edge.
REQ-036 ld with mem_rdy low 3 cycles in T1 and T6 -> each step held 3 extra cycles, ctrl unchanged while held, total 14 cycles.
REQ-037 mem_rdy held low 15 cycles in T1 -> fault=1, ctrl=0, stays until clr.
REQ-038 br with con_ff=0 -> T6 ctrl has no PCin; con_ff=1 -> T6 ctrl=Zlowout|PCin.
REQ-039 ir=halt -> halted=1 after T3; run=1 -> T0; ir=5'h1F -> fault=1.
REQ-040 mul with CTRL_SEQ_MULDIV_EN -> T5 LOin, T6 HIin; without macro -> fault=1 after T3.
